// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared encodings for the instruction-fetch front end:
//               pc_sel encoding, NOP word, address regions, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // pc_sel encoding shared with control_logic (2'd3 is reserved, acts as PC+4)
    localparam logic [1:0]  c_pc_sel_jal  = 2'd0;
    localparam logic [1:0]  c_pc_sel_alu  = 2'd1;
    localparam logic [1:0]  c_pc_sel_pc4  = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] c_nop_inst    = 32'h0000_0013;

    // Address regions decoded from the top nibble of the PC
    localparam logic [3:0]  c_region_bios = 4'h4;
    localparam logic [3:0]  c_region_imem = 4'h1;

    // Fetch FSM encodings
    localparam logic [1:0]  c_st_boot     = 2'd0;
    localparam logic [1:0]  c_st_run      = 2'd1;
    localparam logic [1:0]  c_st_hold     = 2'd2;

    // True when the region nibble maps onto a memory that can return instructions
    function automatic logic is_fetch_region(input logic [3:0] region);
        return (region == c_region_bios) || (region == c_region_imem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hold_buf
// Description : Holds the F/D instruction while fetch is stalled. The word
//               returned by the synchronous memory is only valid for one
//               cycle, so it is captured on entry to the stall and replayed.
//               A redirect flushes it.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buf
    import fetch_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    // Capture on the RUN->HOLD edge; flush (wrong path) takes priority
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_data  <= DATA_W'(c_nop_inst);
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end of the 3-stage core. Owns the PC,
//               drives the next-fetch address to BIOS/IMEM, pairs returned
//               words with their PC and squashes wrong-path instructions.
//               Optional performance counters: define FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                   PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = 32'h4000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [1:0]          pc_sel,
    input  logic [PC_WIDTH-1:0] jal_target,
    input  logic [PC_WIDTH-1:0] alu_target,
    input  logic [31:0]         bios_rdata,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] fetch_addr,
    output logic [PC_WIDTH-1:0] pc_fd,
    output logic [31:0]         inst_fd,
    output logic                valid_fd
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         bubble_cnt
`endif
);

    localparam logic [PC_WIDTH-1:0] c_align_mask = ~PC_WIDTH'(3);

    logic [PC_WIDTH-1:0] r_pc_fd;
    logic [1:0]          r_state;

    logic                w_redirect;
    logic [3:0]          w_region;
    logic                w_src_ok;
    logic [31:0]         w_src_inst;
    logic                w_hold_capture;
    logic [31:0]         w_hold_data;
    logic                w_hold_valid;
    logic                w_valid;
    logic [31:0]         w_inst;

    assign w_redirect = (pc_sel == c_pc_sel_alu);

    // Next-fetch address: reset, then X redirect (beats stall), stall, JAL, PC+4
    always_comb begin
        fetch_addr = r_pc_fd + PC_WIDTH'(4);
        if (rst) begin
            fetch_addr = RESET_PC;
        end else if (w_redirect) begin
            fetch_addr = alu_target & c_align_mask;
        end else if (stall) begin
            fetch_addr = r_pc_fd;
        end else if (pc_sel == c_pc_sel_jal) begin
            fetch_addr = jal_target & c_align_mask;
        end
    end

    // PC of the word currently returning from memory
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_fd <= RESET_PC;
        end else begin
            r_pc_fd <= fetch_addr;
        end
    end

    // Source memory select from the PC region
    assign w_region   = r_pc_fd[PC_WIDTH-1 -: 4];
    assign w_src_ok   = is_fetch_region(w_region);
    assign w_src_inst = (w_region == c_region_bios) ? bios_rdata :
                        (w_region == c_region_imem) ? imem_rdata : c_nop_inst;

    // Fetch FSM: BOOT for one cycle after reset, RUN normally, HOLD while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_boot;
        end else begin
            case (r_state)
                c_st_boot: if (!(stall && !w_redirect)) r_state <= c_st_run;
                c_st_run:  if (stall && !w_redirect)    r_state <= c_st_hold;
                c_st_hold: if (!stall || w_redirect)    r_state <= c_st_run;
                default:   r_state <= c_st_boot;
            endcase
        end
    end

    assign w_hold_capture = (r_state == c_st_run) && stall && !w_redirect;

    fetch_hold_buf #(
        .DATA_W (32)
    ) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_hold_capture),
        .i_flush   (w_redirect),
        .i_data    (w_src_inst),
        .i_valid   (w_src_ok),
        .o_data    (w_hold_data),
        .o_valid   (w_hold_valid)
    );

    // F/D presentation; a redirect kills the wrong-path instruction this cycle
    always_comb begin
        w_valid = 1'b0;
        w_inst  = c_nop_inst;
        case (r_state)
            c_st_run: begin
                if (w_src_ok && !w_redirect) begin
                    w_valid = 1'b1;
                    w_inst  = w_src_inst;
                end
            end
            c_st_hold: begin
                if (w_hold_valid && !w_redirect) begin
                    w_valid = 1'b1;
                    w_inst  = w_hold_data;
                end
            end
            default: begin
                w_valid = 1'b0;
                w_inst  = c_nop_inst;
            end
        endcase
    end

    assign pc_fd    = r_pc_fd;
    assign inst_fd  = w_inst;
    assign valid_fd = w_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Issued instructions and bubble cycles, both free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_valid && !stall) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            if (!w_valid)          r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage: reset, sequential
//               fetch, JAL, redirect, stall/hold, redirect during stall,
//               invalid region, PC wrap, stall in BOOT, reset mid-stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] jal_target;
    logic [31:0] alu_target;
    logic [31:0] bios_rdata;
    logic [31:0] imem_rdata;
    logic [31:0] fetch_addr;
    logic [31:0] pc_fd;
    logic [31:0] inst_fd;
    logic        valid_fd;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] r_snap;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_WIDTH (32),
        .RESET_PC (32'h4000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pc_sel     (pc_sel),
        .jal_target (jal_target),
        .alu_target (alu_target),
        .bios_rdata (bios_rdata),
        .imem_rdata (imem_rdata),
        .fetch_addr (fetch_addr),
        .pc_fd      (pc_fd),
        .inst_fd    (inst_fd),
        .valid_fd   (valid_fd)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; pc_sel = 2'd2;
        jal_target = 32'h0; alu_target = 32'h0;
        bios_rdata = 32'h0; imem_rdata = 32'h0;

        // Reset
        #1;
        chk("rst_faddr", fetch_addr, 32'h4000_0000);
        cyc();
        chk("rst_faddr2", fetch_addr, 32'h4000_0000);
        chk("rst_pc", pc_fd, 32'h4000_0000);
        chk("rst_valid", {31'd0, valid_fd}, 32'd0);
        cyc();
        rst = 1'b0; #1;
        chk("boot_pc", pc_fd, 32'h4000_0000);
        chk("boot_valid", {31'd0, valid_fd}, 32'd0);
        chk("boot_inst", inst_fd, 32'h0000_0013);
        chk("boot_faddr", fetch_addr, 32'h4000_0004);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fcnt", fetch_cnt, 32'd0);
`endif

        // Sequential fetch from BIOS
        bios_rdata = 32'h0050_0113;
        cyc();
        chk("seq_pc1", pc_fd, 32'h4000_0004);
        chk("seq_valid1", {31'd0, valid_fd}, 32'd1);
        chk("seq_inst1", inst_fd, 32'h0050_0113);
        chk("seq_faddr1", fetch_addr, 32'h4000_0008);
        bios_rdata = 32'h0060_0193; #1;
        cyc();
        chk("seq_pc2", pc_fd, 32'h4000_0008);
        chk("seq_inst2", inst_fd, 32'h0060_0193);
        cyc();
        cyc();
        chk("seq_pc4", pc_fd, 32'h4000_0010);

        // JAL: no bubble
        bios_rdata = 32'h0040_026F; pc_sel = 2'd0; jal_target = 32'h4000_0014; #1;
        chk("jal_valid", {31'd0, valid_fd}, 32'd1);
        chk("jal_inst", inst_fd, 32'h0040_026F);
        chk("jal_faddr", fetch_addr, 32'h4000_0014);
        cyc();
        pc_sel = 2'd2; bios_rdata = 32'h0000_0093; #1;
        chk("jal_tgt_pc", pc_fd, 32'h4000_0014);
        chk("jal_tgt_valid", {31'd0, valid_fd}, 32'd1);

        // Redirect with unaligned ALU target into IMEM
        pc_sel = 2'd1; alu_target = 32'h1000_0023; #1;
        chk("redir_kill_valid", {31'd0, valid_fd}, 32'd0);
        chk("redir_kill_inst", inst_fd, 32'h0000_0013);
        chk("redir_faddr", fetch_addr, 32'h1000_0020);
        cyc();
        pc_sel = 2'd2; imem_rdata = 32'h00A0_0293; bios_rdata = 32'hDEAD_BEEF; #1;
        chk("redir_pc", pc_fd, 32'h1000_0020);
        chk("redir_valid", {31'd0, valid_fd}, 32'd1);
        chk("redir_inst", inst_fd, 32'h00A0_0293);
        chk("redir_faddr2", fetch_addr, 32'h1000_0024);
        cyc();

        // Stall three cycles while memory data keeps changing
        stall = 1'b1; imem_rdata = 32'h1111_1111; #1;
        chk("stall0_inst", inst_fd, 32'h1111_1111);
        chk("stall0_faddr", fetch_addr, 32'h1000_0024);
        cyc();
        imem_rdata = 32'h2222_2222; #1;
        chk("stall1_inst", inst_fd, 32'h1111_1111);
        chk("stall1_pc", pc_fd, 32'h1000_0024);
        chk("stall1_faddr", fetch_addr, 32'h1000_0024);
        chk("stall1_valid", {31'd0, valid_fd}, 32'd1);
        cyc();
        imem_rdata = 32'h3333_3333; #1;
        chk("stall2_inst", inst_fd, 32'h1111_1111);
        chk("stall2_pc", pc_fd, 32'h1000_0024);
        cyc();
        stall = 1'b0; imem_rdata = 32'h4444_4444; #1;
        chk("unstall_inst", inst_fd, 32'h1111_1111);
        chk("unstall_faddr", fetch_addr, 32'h1000_0028);
        cyc();
        imem_rdata = 32'h5555_5555; #1;
        chk("resume_pc", pc_fd, 32'h1000_0028);
        chk("resume_inst", inst_fd, 32'h5555_5555);

        // Redirect while in HOLD
        stall = 1'b1; imem_rdata = 32'h6666_6666; #1;
        cyc();
        pc_sel = 2'd1; alu_target = 32'h4000_0100; imem_rdata = 32'h7777_7777; #1;
`ifdef FETCH_PERF_CNT_EN
        r_snap = bubble_cnt;
`endif
        chk("hredir_valid", {31'd0, valid_fd}, 32'd0);
        chk("hredir_inst", inst_fd, 32'h0000_0013);
        chk("hredir_faddr", fetch_addr, 32'h4000_0100);
        cyc();
        stall = 1'b0; pc_sel = 2'd2; bios_rdata = 32'h0000_A0B7; #1;
        chk("hredir_pc", pc_fd, 32'h4000_0100);
        chk("hredir_tvalid", {31'd0, valid_fd}, 32'd1);
        chk("hredir_tinst", inst_fd, 32'h0000_A0B7);
`ifdef FETCH_PERF_CNT_EN
        chk("bubble_inc", bubble_cnt, r_snap + 32'd1);
        r_snap = fetch_cnt;
        cyc();
        chk("fetch_inc", fetch_cnt, r_snap + 32'd1);
`endif

        // Unmapped region yields NOP, invalid
        pc_sel = 2'd1; alu_target = 32'h2000_0000; #1;
        cyc();
        pc_sel = 2'd2; #1;
        chk("region_pc", pc_fd, 32'h2000_0000);
        chk("region_valid", {31'd0, valid_fd}, 32'd0);
        chk("region_inst", inst_fd, 32'h0000_0013);

        // PC+4 wraps modulo 2^32; reserved pc_sel acts as PC+4
        pc_sel = 2'd1; alu_target = 32'hFFFF_FFFC; #1;
        cyc();
        pc_sel = 2'd2; #1;
        chk("wrap_pc", pc_fd, 32'hFFFF_FFFC);
        chk("wrap_faddr", fetch_addr, 32'h0000_0000);
        cyc();
        chk("wrap_pc0", pc_fd, 32'h0000_0000);
        pc_sel = 2'd3; #1;
        chk("sel3_faddr", fetch_addr, 32'h0000_0004);

        // Stall in BOOT keeps BOOT and RESET_PC
        rst = 1'b1; #1;
        chk("rst_prio_faddr", fetch_addr, 32'h4000_0000);
        cyc();
        rst = 1'b0; stall = 1'b1; pc_sel = 2'd2; bios_rdata = 32'h1234_5678; #1;
        chk("bstall_faddr", fetch_addr, 32'h4000_0000);
        chk("bstall_valid", {31'd0, valid_fd}, 32'd0);
        cyc();
        chk("bstall_valid2", {31'd0, valid_fd}, 32'd0);
        chk("bstall_pc2", pc_fd, 32'h4000_0000);
        stall = 1'b0; #1;
        chk("bstall_faddr3", fetch_addr, 32'h4000_0004);
        cyc();
        chk("bstall_pc3", pc_fd, 32'h4000_0004);
        chk("bstall_valid3", {31'd0, valid_fd}, 32'd1);
        chk("bstall_inst3", inst_fd, 32'h1234_5678);

        // Reset during HOLD
        stall = 1'b1; #1;
        cyc();
        rst = 1'b1; #1;
        chk("rstst_faddr", fetch_addr, 32'h4000_0000);
        cyc();
        rst = 1'b0; stall = 1'b0; #1;
        chk("rstst_pc", pc_fd, 32'h4000_0000);
        chk("rstst_valid", {31'd0, valid_fd}, 32'd0);
        chk("rstst_inst", inst_fd, 32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
        chk("rstst_bcnt", bubble_cnt, 32'd0);
        chk("rstst_fcnt", fetch_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
